reaction_timer_mp: RTL

Parametrised multi-player reaction-timer core: the successor to the single-player light/random-delay/count chain. It runs a light sequence on `ledr` and holds all lights for a pseudo-random delay. It then times each player's reaction in milliseconds, flags false starts, picks a winner and tracks a best time across runs. It sits between the debounced key/button inputs and the BCD/7-segment display path.

---
 rtl/reaction_pkg.sv | 14 +
 rtl/reaction_timer_mp_ms_tick.sv | 27 ++
 rtl/reaction_timer_mp.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
package reaction_pkg;

    typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, TIMING, DONE} state_t;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_mp_ms_tick.sv
// Millisecond tick divider: one-cycle tick every TICK_DIV clocks, restartable.
module ms_tick #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (restart || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: light sequence, random hold, per-player timing,
// false-start detection, winner selection and best-time tracking.
module reaction_timer_mp
    import reaction_pkg::*;
#(
    parameter int unsigned N_PLAYERS    = 2,
    parameter int unsigned N_LIGHTS     = 10,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned LIGHT_MS     = 500,
    parameter int unsigned MIN_DELAY_MS = 250,
    parameter int unsigned DELAY_W      = 11,
    parameter int unsigned TIME_W       = 16,
    localparam int unsigned WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          clr_best,
    input  logic [N_PLAYERS-1:0]          react,
    output logic [N_LIGHTS-1:0]           ledr,
    output logic                          busy,
    output logic                          done,
    output logic [N_PLAYERS*TIME_W-1:0]   rtime,
    output logic [N_PLAYERS-1:0]          valid,
    output logic [N_PLAYERS-1:0]          false_start,
    output logic [WIN_W-1:0]              winner,
    output logic                          win_valid,
    output logic [TIME_W-1:0]             best_time
);

    localparam int unsigned DLY_MAX = MIN_DELAY_MS + (1 << DELAY_W) - 1;
    localparam int unsigned PH_MAX  = (DLY_MAX > LIGHT_MS) ? DLY_MAX : LIGHT_MS;
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
    localparam int unsigned ST_W    = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;

    state_t              state, state_nxt;
    logic [15:0]         lfsr;
    logic                tick, restart;
    logic [PH_W-1:0]     phase, delay;
    logic [PH_W:0]       phase_inc;
    logic [ST_W-1:0]     step;
    logic [TIME_W-1:0]   tcnt;
    logic [N_PLAYERS-1:0] react_q, rise, fs_set;
    logic                start_ok, phase_last, lights_done, hold_done;
    logic                all_fs, timing_exit, done_entry;
    logic [TIME_W-1:0]   min_time;
    logic [WIN_W-1:0]    min_idx;
    logic                min_found;

    logic [TIME_W-1:0]   rt_q [N_PLAYERS];
    logic                vl_q [N_PLAYERS];
    logic                fs_q [N_PLAYERS];

    ms_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign start_ok    = start && (state == IDLE || state == DONE);
    assign phase_last  = tick && (phase == PH_W'(LIGHT_MS - 1));
    assign lights_done = phase_last && (step == ST_W'(N_LIGHTS - 1));
    assign phase_inc   = {1'b0, phase} + 1'b1;
    assign hold_done   = tick && (phase_inc >= {1'b0, delay});
    assign rise        = react & ~react_q;
    assign fs_set      = rise & {N_PLAYERS{state == LIGHTS || state == HOLD}};
    assign all_fs      = &(false_start | fs_set);
    assign timing_exit = (&(valid | false_start)) || (tcnt == '1);
    assign busy        = (state == LIGHTS) || (state == HOLD) || (state == TIMING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LIGHTS;
                    restart   = 1'b1;
                end
            end
            LIGHTS: begin
                if (all_fs)           state_nxt = DONE;
                else if (lights_done) state_nxt = HOLD;
            end
            HOLD: begin
                if (all_fs) state_nxt = DONE;
                else if (hold_done) begin
                    state_nxt = TIMING;
                    restart   = 1'b1;
                end
            end
            TIMING: begin
                if (timing_exit) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done_entry = (state_nxt == DONE) && (state != DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr    <= LFSR_SEED;
            react_q <= '0;
            phase   <= '0;
            delay   <= '0;
            step    <= '0;
            tcnt    <= '0;
            ledr    <= '0;
        end else begin
            lfsr    <= lfsr_next(lfsr);
            react_q <= react;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ledr  <= N_LIGHTS'(1);
                        phase <= '0;
                        step  <= '0;
                    end
                end
                LIGHTS: begin
                    if (all_fs)
                        ledr <= '0;
                    else if (phase_last) begin
                        phase <= '0;
                        if (lights_done)
                            delay <= PH_W'(MIN_DELAY_MS) + PH_W'(lfsr[DELAY_W-1:0]);
                        else begin
                            step <= step + 1'b1;
                            ledr <= (ledr << 1) | N_LIGHTS'(1);
                        end
                    end else if (tick)
                        phase <= phase + 1'b1;
                end
                HOLD: begin
                    if (all_fs)
                        ledr <= '0;
                    else if (hold_done) begin
                        ledr <= '0;
                        tcnt <= '0;
                    end else if (tick)
                        phase <= phase + 1'b1;
                end
                TIMING: begin
                    if (tick && tcnt != '1)
                        tcnt <= tcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A press on the saturating cycle is dropped so results settle before DONE entry
    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
        logic cap;
        assign cap = rise[i] && state == TIMING && !timing_exit && !vl_q[i] && !fs_q[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rt_q[i] <= '0;
                vl_q[i] <= 1'b0;
                fs_q[i] <= 1'b0;
            end else if (start_ok) begin
                rt_q[i] <= '0;
                vl_q[i] <= 1'b0;
                fs_q[i] <= 1'b0;
            end else begin
                if (fs_set[i])
                    fs_q[i] <= 1'b1;
                if (cap) begin
                    rt_q[i] <= tcnt;
                    vl_q[i] <= 1'b1;
                end else if (state == TIMING && timing_exit && !vl_q[i])
                    rt_q[i] <= '1;
            end
        end

        assign rtime[i*TIME_W +: TIME_W] = rt_q[i];
        assign valid[i]                  = vl_q[i];
        assign false_start[i]            = fs_q[i];
    end

    always_comb begin
        min_time  = '1;
        min_idx   = '0;
        min_found = 1'b0;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            if (vl_q[i] && (!min_found || rt_q[i] < min_time)) begin
                min_time  = rt_q[i];
                min_idx   = WIN_W'(i);
                min_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            winner    <= '0;
            win_valid <= 1'b0;
            best_time <= '1;
        end else begin
            if (start_ok) begin
                done      <= 1'b0;
                win_valid <= 1'b0;
                winner    <= '0;
            end else if (done_entry) begin
                done      <= 1'b1;
                winner    <= min_idx;
                win_valid <= min_found;
            end
            if (clr_best)
                best_time <= '1;
            else if (done_entry && min_found && min_time < best_time)
                best_time <= min_time;
        end
    end

endmodule
